// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver/transmitter types, constants and divider derivation
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam int DATA_BITS = 8;
  function automatic int calc_div(input int clk_freq, input int baud, input int os);
    return clk_freq / (baud * os);
  endfunction
endpackage

// File: rtl/uart_rx_deserializer_if.sv
// uart_rx_deserializer_if: serial line in, received byte and status pulses out
interface uart_rx_deserializer_if;
  logic                           rx;
  logic [uart_pkg::DATA_BITS-1:0] rx_data;
  logic                           rx_valid;
  logic                           rx_ferr;
  logic                           rx_busy;
  modport master (output rx, input rx_data, rx_valid, rx_ferr, rx_busy);
  modport slave (input rx, output rx_data, rx_valid, rx_ferr, rx_busy);
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider pulsing tick every DIV clocks, restartable by clr
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [W-1:0] TOP = W'(DIV - 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign tick  = !clr && cnt_q == TOP;
  assign cnt_d = (clr || tick) ? '0 : cnt_q + 1'b1;
  // divider count, wraps at DIV-1 and restarts on clr
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: 8N1 receiver with 16x oversampling, mid-bit sampling and framing check
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  uart_rx_deserializer_if.slave bus
);
  localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS);
  localparam logic [SW-1:0] MID      = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] LAST     = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  state_t               state_q, state_d;
  logic                 s1_q, s2_q, prev_q;
  logic [1:0]           live_q;
  logic [SW-1:0]        smp_q, smp_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
  logic                 valid_q, valid_d, ferr_q, ferr_d, busy_q;
  logic                 fall, clr, tick;
  // prev_q only reports a high line once the synchronizer holds real samples,
  // so a line already low when reset releases is never mistaken for a start edge
  assign fall = prev_q && !s2_q;
  assign clr  = state_q == IDLE && fall;
  assign bus.rx_data  = data_q;
  assign bus.rx_valid = valid_q;
  assign bus.rx_ferr  = ferr_q;
  assign bus.rx_busy  = busy_q;
  uart_baud_tick #(.DIV(DIV)) u_tick (.clk(clk), .rst_n(rst_n), .clr(clr), .tick(tick));
  // frame FSM: start qualification, mid-bit data sampling, stop check
  always_comb begin
    state_d = state_q;
    smp_d   = smp_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: if (fall) begin
        state_d = START;
        smp_d   = '0;
      end
      START: if (tick) begin
        smp_d = smp_q == MID ? '0 : smp_q + 1'b1;
        if (smp_q == MID) begin
          state_d = s2_q ? IDLE : DATA;
          bit_d   = '0;
        end
      end
      DATA: if (tick) begin
        smp_d = smp_q == LAST ? '0 : smp_q + 1'b1;
        if (smp_q == LAST) begin
          shift_d = {s2_q, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
          state_d = bit_q == LAST_BIT ? STOP : DATA;
        end
      end
      default: if (tick) begin
        smp_d = smp_q == LAST ? '0 : smp_q + 1'b1;
        if (smp_q == LAST) begin
          state_d = IDLE;
          valid_d = s2_q;
          ferr_d  = !s2_q;
          data_d  = s2_q ? shift_q : data_q;
        end
      end
    endcase
  end
  // synchronizer, edge history, FSM state and registered outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      live_q  <= '0;
      prev_q  <= 1'b0;
      state_q <= IDLE;
      smp_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      s1_q    <= bus.rx;
      s2_q    <= s1_q;
      live_q  <= {live_q[0], 1'b1};
      prev_q  <= live_q[1] && s2_q;
      state_q <= state_d;
      smp_q   <= smp_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      busy_q  <= state_d != IDLE;
    end
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb_uart_rx_deserializer: directed and random 8N1 frames checked against a frame-level model
module tb_uart_rx_deserializer;
  localparam int CLK_FREQ = 16_000_000;
  localparam int BAUD     = 1_000_000;
  localparam int OS       = 16;
  localparam int BIT_CLK  = CLK_FREQ / BAUD;
  localparam int LAT      = 2 + (OS / 2 - 1 + 9 * OS) * (CLK_FREQ / (BAUD * OS)) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0, na = 0, nf = 0, nferr = 0, nboth = 0, nbusy = 0, snap = 0;
  logic busy_prev = 1'b0;
  logic [7:0] vq[$], exq[$];
  int         tq[$], fq[$];
  logic       bfq[$];

  uart_rx_deserializer_if bus ();
  uart_rx_deserializer #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // observe outputs mid-cycle and log every pulse
  always @(negedge clk) begin
    if (bus.rx_valid) begin
      vq.push_back(bus.rx_data);
      tq.push_back(cyc);
      bfq.push_back(busy_prev && !bus.rx_busy);
    end
    if (bus.rx_ferr) nferr++;
    if (bus.rx_valid && bus.rx_ferr) nboth++;
    if (bus.rx_busy) nbusy++;
    busy_prev = bus.rx_busy;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    na++;
    assert (got === exp) else begin
      nf++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tx_bit(input logic b);
    bus.rx = b;
    repeat (BIT_CLK) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    if (stop) begin
      exq.push_back(b);
      fq.push_back(cyc);
    end
    tx_bit(1'b0);
    for (int i = 0; i < 8; i++) tx_bit(b[i]);
    tx_bit(stop);
  endtask

  task automatic check_frames(input string tag);
    int lat;
    check({tag, "_nvalid"}, vq.size(), exq.size());
    while (vq.size() > 0 && exq.size() > 0) begin
      check({tag, "_data"}, vq.pop_front(), exq.pop_front());
      lat = tq.pop_front() - fq.pop_front();
      na++;
      assert (lat >= LAT - 1 && lat <= LAT + 1) else begin
        nf++;
        $error("FAIL %s_latency got %0d expected %0d+-1", tag, lat, LAT);
      end
      check({tag, "_busy_fall"}, bfq.pop_front(), 1);
    end
    vq.delete(); exq.delete(); tq.delete(); fq.delete(); bfq.delete();
  endtask

  initial begin
    logic [7:0] c3, b;
    c3 = 8'hC3;
    bus.rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_data", bus.rx_data, 8'h00);
    check("reset_valid", bus.rx_valid, 0);
    check("reset_ferr", bus.rx_ferr, 0);
    check("reset_busy", bus.rx_busy, 0);
    rst_n = 1'b1;
    idle(8);

    send_frame(8'h55, 1'b1);
    idle(20);
    check_frames("t1");
    check("t1_ferr", nferr, 0);

    send_frame(8'hA5, 1'b1);
    send_frame(8'h3C, 1'b1);
    idle(20);
    check_frames("t2");

    nbusy = 0;
    bus.rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle(30);
    na++;
    assert (nbusy >= 7 && nbusy <= 9) else begin
      nf++;
      $error("FAIL t3_busy_len got %0d expected 8+-1", nbusy);
    end
    check_frames("t3");
    check("t3_ferr", nferr, 0);
    check("t3_busy_end", bus.rx_busy, 0);

    nferr = 0;
    send_frame(8'h12, 1'b1);
    send_frame(8'hFF, 1'b0);
    snap = nbusy;
    repeat (40) @(posedge clk);
    #1;
    check("t4_held_low_busy", nbusy - snap, 0);
    idle(20);
    check_frames("t4");
    check("t4_ferr", nferr, 1);
    check("t4_data_hold", bus.rx_data, 8'h12);
    check("t4_busy", bus.rx_busy, 0);

    nferr = 0;
    tx_bit(1'b0);
    for (int i = 0; i < 3; i++) tx_bit(c3[i]);
    bus.rx = c3[3];
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_rst_data", bus.rx_data, 8'h00);
    check("t5_rst_valid", bus.rx_valid, 0);
    check("t5_rst_ferr", bus.rx_ferr, 0);
    check("t5_rst_busy", bus.rx_busy, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (BIT_CLK - 11) @(posedge clk);
    #1;
    for (int i = 4; i < 8; i++) tx_bit(c3[i]);
    tx_bit(1'b1);
    idle(30);
    check_frames("t5_discard");
    check("t5_discard_ferr", nferr, 0);
    send_frame(8'h81, 1'b1);
    idle(20);
    check_frames("t5");
    check("t5_data", bus.rx_data, 8'h81);

    send_frame(8'h00, 1'b1);
    idle(20);
    check_frames("t6");
    check("t6_ferr", nferr, 0);

    for (int k = 0; k < 8; k++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1);
      idle($urandom_range(0, 5));
    end
    idle(30);
    check_frames("rand");
    check("rand_ferr", nferr, 0);
    check("valid_ferr_overlap", nboth, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", na, nf);
    $finish;
  end
endmodule
